present_avalon: RTL and testbench
=================================

# present_avalon

Avalon-MM slave front-end feeding the PRESENT-128 encryption core in the accelerator. Exposes key, plaintext, control, status, ciphertext and a cycle counter as 32-bit registers. Sequences the core's start/eoc handshake and holds operands stable while the core runs. It instantiates nothing; the core is wired to the `core_*` ports at the accelerator top.

## Interface

- `CNT_W`, default 16: width of the operation cycle counter (saturating).
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: synchronous reset, active-low.
- `address` in 4: word address.
- `read` in 1: read strobe.
- `write` in 1: write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data, registered, valid the cycle after `read`.
- `readdatavalid` out 1: high exactly one cycle after each `read`.
- `irq` out 1: completion interrupt, level.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_eoc` in 1: core end-of-computation.
- `core_plaintext` out 64: `{PT1,PT0}`.
- `core_key` out 128: `{KEY3,KEY2,KEY1,KEY0}`.
- `core_ciphertext` in 64: core result.

## Operation

- Register map (word address):
  - 0–3: KEY0–KEY3, RW.
  - 4–5: PT0–PT1, RW.
  - 6–7: CT0–CT1, RO (captured ciphertext low/high).
  - 8: CTRL. Bit0 START, write 1 to launch, reads 0. Bit1 IE, RW.
  - 9: STATUS. Bit0 BUSY, RO. Bit1 DONE, sticky, write 1 to clear.
  - 10: CYCLES, RO, zero-extended.
  - 11–15: read 0; writes ignored.
- FSM states: IDLE, LAUNCH, RUN.
  - IDLE: a CTRL write with bit0=1 goes to LAUNCH and clears DONE and CYCLES.
  - LAUNCH: `core_start`=1 for this one cycle, then go to RUN.
  - RUN: completion is a rising edge of `core_eoc` (`core_eoc` high and previous-cycle sample low). Stale high `eoc` from a previous operation is ignored. On completion: capture `core_ciphertext` into CT0/CT1, set DONE, return to IDLE.
- BUSY = 1 in LAUNCH and RUN.
- Writes to KEY/PT/CTRL.START while BUSY are ignored, so operands stay frozen. IE stays writable.
- CYCLES counts cycles in RUN, including the completion cycle, and saturates at all-ones.
- Same-cycle DONE W1C write and completion: the set wins, DONE=1.
- Same-cycle `read` and `write` to the same address: `readdata` returns the pre-write value.

## Timing

- Reset (nrst=0 at a rising edge) gives:
  - all registers 0, FSM in IDLE;
  - `readdata`=0, `readdatavalid`=0, `core_start`=0, `irq`=0;
  - the eoc edge-detect flop cleared.
- Reset mid-operation aborts: no capture, DONE=0. The core is reset by the same `nrst`.
- START write at cycle T: `core_start` high at T+1. RUN begins at T+2.
- Completion edge seen at cycle C: CT/DONE/CYCLES update at C+1. BUSY reads 0 from C+1.
- Read latency is fixed at 1. There is no waitrequest.
- Back-to-back START is possible from C+1, the first IDLE cycle.

## Configuration

- `PRESENT_AVALON_IRQ_EN` defined:
  - `irq` = DONE & IE, registered, and follows DONE clear one cycle later.
  - CTRL bit1 is implemented.
- Undefined:
  - `irq` tied 0.
  - CTRL bit1 reads 0 and writes to it are ignored.
  - The IE flop is not built.

## Test plan

- Reset check: reads of all 16 addresses return 0; `irq`=0, `core_start`=0.
- Known vector: write KEY0–3=0 and PT0–1=0, then CTRL=1.
  - Exactly one `core_start` pulse occurs.
  - After eoc: CT1=0x96db702a, CT0=0x2e6900af, STATUS=0x2.
  - CYCLES equals the number of RUN cycles observed.
- Busy protection: write KEY0=0xdeadbeef and CTRL=1 during RUN.
  - KEY0 is unchanged.
  - No second `core_start`.
  - The result matches the original operands.
- Stale eoc: model `core_eoc` held high through LAUNCH and the first RUN cycle, then low, then high again. Completion fires only on the second rise.
- DONE race: issue a STATUS W1C write (bit1) in the completion cycle → DONE=1. A later W1C → DONE=0.
- IRQ, with macro defined: CTRL=0x2 then START → `irq`=1 one cycle after DONE sets. W1C DONE → `irq`=0 the following cycle. Without the macro, `irq` stays 0 throughout.

Source files
------------

// File: rtl/present_avalon.sv
// Avalon-MM register front-end for the PRESENT-128 encryption core.
// Holds key/plaintext operands, sequences the core start/eoc handshake, captures the
// ciphertext and counts the cycles an operation spends running.
// Optional feature: define PRESENT_AVALON_IRQ_EN to build the IE bit and the level irq.
module present_avalon #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [3:0]   address,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         readdatavalid,
  output logic         irq,
  output logic         core_start,
  input  logic         core_eoc,
  output logic [63:0]  core_plaintext,
  output logic [127:0] core_key,
  input  logic [63:0]  core_ciphertext
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_e;

  state_e             state_q, state_d;
  logic [3:0][31:0]   key_q;
  logic [1:0][31:0]   pt_q;
  logic [1:0][31:0]   ct_q;
  logic               done_q;
  logic [CNT_W-1:0]   cycles_q;
  logic               eoc_q;
  logic [31:0]        readdata_q;
  logic [31:0]        rdata_d;
  logic               rvalid_q;
  logic               ie;

  logic busy;
  logic complete;
  logic start_req;
  logic wr_ctrl;
  logic wr_status;

  assign busy      = (state_q != StIdle);
  assign wr_ctrl   = write && (address == 4'd8);
  assign wr_status = write && (address == 4'd9);
  assign start_req = wr_ctrl && writedata[0] && !busy;
  // Only a fresh rising edge counts; eoc left high by the previous operation is ignored.
  assign complete  = (state_q == StRun) && core_eoc && !eoc_q;

  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign readdata       = readdata_q;
  assign readdatavalid  = rvalid_q;

  // Next-state logic and the one-cycle start pulse.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    unique case (state_q)
      StIdle:   if (start_req) state_d = StLaunch;
      StLaunch: begin
        core_start = 1'b1;
        state_d    = StRun;
      end
      StRun:    if (complete) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM state and eoc edge-detect flop.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eoc_q   <= core_eoc;
    end
  end

  // Operand registers; frozen while an operation is in flight.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      key_q <= '0;
      pt_q  <= '0;
    end else if (write && !busy) begin
      if (address[3:2] == 2'b00) key_q[address[1:0]] <= writedata;
      else if (address[3:1] == 3'b010) pt_q[address[0]] <= writedata;
    end
  end

  // Result capture, sticky DONE (set beats W1C) and saturating cycle counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ct_q     <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      if (complete) ct_q <= core_ciphertext;

      if (start_req)                      done_q <= 1'b0;
      else if (complete)                  done_q <= 1'b1;
      else if (wr_status && writedata[1]) done_q <= 1'b0;

      if (start_req) cycles_q <= '0;
      else if ((state_q == StRun) && (cycles_q != '1)) cycles_q <= cycles_q + CNT_W'(1);
    end
  end

`ifdef PRESENT_AVALON_IRQ_EN
  logic ie_q;
  logic irq_q;

  // Interrupt enable stays writable while busy.
  always_ff @(posedge clk) begin
    if (!nrst)        ie_q <= 1'b0;
    else if (wr_ctrl) ie_q <= writedata[1];
  end

  // Registered level interrupt, trails DONE by one cycle.
  always_ff @(posedge clk) begin
    if (!nrst) irq_q <= 1'b0;
    else       irq_q <= done_q & ie_q;
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rdata_d = '0;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3: rdata_d = key_q[address[1:0]];
      4'd4, 4'd5:             rdata_d = pt_q[address[0]];
      4'd6, 4'd7:             rdata_d = ct_q[address[0]];
      4'd8:                   rdata_d = {30'd0, ie, 1'b0};
      4'd9:                   rdata_d = {30'd0, done_q, busy};
      4'd10:                  rdata_d = 32'(cycles_q);
      default:                rdata_d = '0;
    endcase
  end

  // Fixed one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= read;
      if (read) readdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_present_avalon.sv
// Self-checking bench for present_avalon: a bus driver, a scripted core model and a
// behavioural PRESENT-128 reference used to predict every captured ciphertext.
module tb_present_avalon;

  localparam int unsigned CW = 4;
  localparam int unsigned CMax = (1 << CW) - 1;
`ifdef PRESENT_AVALON_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic         clk;
  logic         nrst;
  logic [3:0]   address;
  logic         read;
  logic         write;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic         irq;
  logic         core_start;
  logic         core_eoc;
  logic [63:0]  core_plaintext;
  logic [127:0] core_key;
  logic [63:0]  core_ciphertext;

  int n_cmp;
  int n_fail;
  int starts;

  // Bench-side view of the operands software has written.
  logic [31:0] m_key [4];
  logic [31:0] m_pt [2];

  present_avalon #(.CNT_W(CW)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .address         (address),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .readdata        (readdata),
    .readdatavalid   (readdatavalid),
    .irq             (irq),
    .core_start      (core_start),
    .core_eoc        (core_eoc),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_ciphertext (core_ciphertext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (core_start === 1'b1) starts++;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench still running, required completion");
    $fatal(1);
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [63:0] present128(input logic [127:0] key, input logic [63:0] pt);
    logic [127:0] k;
    logic [63:0]  s;
    logic [63:0]  t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[127:64];
      for (int i = 0; i < 16; i++) s[i*4 +: 4] = sbox(s[i*4 +: 4]);
      t = '0;
      for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
      t[63] = s[63];
      s = t;
      k = {k[66:0], k[127:67]};
      k[127:124] = sbox(k[127:124]);
      k[123:120] = sbox(k[123:120]);
      k[66:62] = k[66:62] ^ 5'(r);
    end
    return s ^ k[127:64];
  endfunction

  function automatic logic [63:0] model_ct();
    return present128({m_key[3], m_key[2], m_key[1], m_key[0]}, {m_pt[1], m_pt[0]});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic load_operands(input bit zero);
    for (int i = 0; i < 4; i++) begin
      m_key[i] = zero ? 32'd0 : $urandom;
      bus_write(4'(i), m_key[i]);
    end
    for (int i = 0; i < 2; i++) begin
      m_pt[i] = zero ? 32'd0 : $urandom;
      bus_write(4'(4 + i), m_pt[i]);
    end
  endtask

  // Core model. Entered in the LAUNCH cycle right after the START write; leaves the DUT
  // one cycle after the completion edge. RUN lasts n+2 cycles including completion.
  task automatic run_op(input int n, input bit stale, input bit intrude, input bit race);
    core_ciphertext = {$urandom, $urandom};
    core_eoc = stale;
    tick();
    core_eoc = stale;
    tick();
    for (int i = 0; i < n; i++) begin
      core_eoc = 1'b0;
      if (intrude && i == 0)      bus_write(4'd0, 32'hdeadbeef);
      else if (intrude && i == 1) bus_write(4'd8, 32'h1);
      else                        tick();
    end
    core_eoc = 1'b1;
    core_ciphertext = present128(core_key, core_plaintext);
    if (race) bus_write(4'd9, 32'h2);
    else      tick();
    core_ciphertext = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    logic [31:0] d;
    nrst = 1'b0; core_eoc = 1'b1; read = 1'b1; write = 1'b0;
    tick(); tick();
    read = 1'b0; nrst = 1'b1; core_eoc = 1'b0;
    for (int i = 0; i < 4; i++) m_key[i] = '0;
    m_pt[0] = '0; m_pt[1] = '0;
    n_cmp++;
    if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rd: valid=%b data=%h, required 0/0", readdatavalid, readdata);
    end
    n_cmp++;
    if (irq !== 1'b0 || core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: irq=%b start=%b, required 0/0", irq, core_start);
    end
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), d);
      n_cmp++;
      if (d !== 32'd0 || readdatavalid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_reg%0d: data=%h valid=%b, required 0/1", a, d, readdatavalid);
      end
    end
    tick();
    n_cmp++;
    if (readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_drop: %b, required 0", readdatavalid);
    end
  endtask

  task automatic test_known_vector();
    logic [31:0] d;
    int s0;
    load_operands(1'b1);
    s0 = starts;
    bus_write(4'd8, 32'h1);
    run_op(3, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL kv_starts: %0d pulses, required 1", starts - s0);
    end
    bus_read(4'd7, d);
    n_cmp++;
    if (d !== 32'h96db702a) begin
      n_fail++;
      $display("FAIL kv_ct1: %h, required 96db702a", d);
    end
    bus_read(4'd6, d);
    n_cmp++;
    if (d !== 32'h2e6900af) begin
      n_fail++;
      $display("FAIL kv_ct0: %h, required 2e6900af", d);
    end
    bus_read(4'd9, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL kv_status: %h, required 2", d);
    end
    bus_read(4'd10, d);
    n_cmp++;
    if (d !== 32'd5) begin
      n_fail++;
      $display("FAIL kv_cycles: %0d, required 5", d);
    end
  endtask

  task automatic test_random_ops();
    logic [31:0] d;
    logic [63:0] exp;
    int n, s0, k;
    bit stale;
    for (int it = 0; it < 5; it++) begin
      load_operands(1'b0);
      k = $urandom_range(0, 5);
      bus_read(4'(k), d);
      n_cmp++;
      if (d !== (k < 4 ? m_key[k] : m_pt[k-4])) begin
        n_fail++;
        $display("FAIL rw_reg%0d: %h, required %h", k, d, (k < 4 ? m_key[k] : m_pt[k-4]));
      end
      stale = 1'($urandom_range(0, 1));
      n = stale ? $urandom_range(1, 6) : $urandom_range(0, 6);
      exp = model_ct();
      s0 = starts;
      bus_write(4'd8, 32'h1);
      run_op(n, stale, 1'b0, 1'b0);
      bus_read(4'd6, d);
      n_cmp++;
      if (d !== exp[31:0]) begin
        n_fail++;
        $display("FAIL rnd_ct0: %h, required %h", d, exp[31:0]);
      end
      bus_read(4'd7, d);
      n_cmp++;
      if (d !== exp[63:32]) begin
        n_fail++;
        $display("FAIL rnd_ct1: %h, required %h", d, exp[63:32]);
      end
      bus_read(4'd10, d);
      n_cmp++;
      if (d !== 32'(n + 2) || starts - s0 !== 1) begin
        n_fail++;
        $display("FAIL rnd_cycles: %0d/%0d starts, required %0d/1", d, starts - s0, n + 2);
      end
    end
  endtask

  task automatic test_busy_protect();
    logic [31:0] d;
    logic [63:0] exp;
    int s0;
    load_operands(1'b0);
    exp = model_ct();
    s0 = starts;
    bus_write(4'd8, 32'h1);
    run_op(4, 1'b0, 1'b1, 1'b0);
    bus_read(4'd0, d);
    n_cmp++;
    if (d !== m_key[0]) begin
      n_fail++;
      $display("FAIL busy_key0: %h, required %h", d, m_key[0]);
    end
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL busy_starts: %0d pulses, required 1", starts - s0);
    end
    bus_read(4'd6, d);
    n_cmp++;
    if (d !== exp[31:0]) begin
      n_fail++;
      $display("FAIL busy_ct0: %h, required %h", d, exp[31:0]);
    end
    tick(); tick();
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL busy_late_start: %0d pulses, required 1", starts - s0);
    end
  endtask

  task automatic test_stale_eoc();
    logic [31:0] d;
    logic [63:0] exp;
    load_operands(1'b0);
    exp = model_ct();
    core_eoc = 1'b1;
    bus_write(4'd8, 32'h1);
    run_op(2, 1'b1, 1'b0, 1'b0);
    bus_read(4'd10, d);
    n_cmp++;
    if (d !== 32'd4) begin
      n_fail++;
      $display("FAIL stale_cycles: %0d, required 4", d);
    end
    bus_read(4'd7, d);
    n_cmp++;
    if (d !== exp[63:32]) begin
      n_fail++;
      $display("FAIL stale_ct1: %h, required %h", d, exp[63:32]);
    end
  endtask

  task automatic test_done_race();
    logic [31:0] d;
    bus_write(4'd8, 32'h1);
    run_op(1, 1'b0, 1'b0, 1'b1);
    bus_read(4'd9, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL race_done: %h, required 2", d);
    end
    bus_write(4'd9, 32'h2);
    bus_read(4'd9, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_done: %h, required 0", d);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    bus_write(4'd8, 32'h1);
    run_op(20, 1'b0, 1'b0, 1'b0);
    bus_read(4'd10, d);
    n_cmp++;
    if (d !== 32'(CMax)) begin
      n_fail++;
      $display("FAIL sat_cycles: %0d, required %0d", d, CMax);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(4'd8, 32'h2);
    bus_read(4'd8, d);
    n_cmp++;
    if (d !== (IrqOn ? 32'h2 : 32'h0)) begin
      n_fail++;
      $display("FAIL ctrl_ie: %h, required %h", d, (IrqOn ? 32'h2 : 32'h0));
    end
    bus_write(4'd8, 32'h3);
    run_op(1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: %b, required 0", irq);
    end
    tick();
    n_cmp++;
    if (irq !== IrqOn) begin
      n_fail++;
      $display("FAIL irq_set: %b, required %b", irq, IrqOn);
    end
    bus_write(4'd9, 32'h2);
    n_cmp++;
    if (irq !== IrqOn) begin
      n_fail++;
      $display("FAIL irq_hold: %b, required %b", irq, IrqOn);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: %b, required 0", irq);
    end
  endtask

  task automatic test_collision_and_ro();
    logic [31:0] d, a, b, ct0, cyc;
    a = $urandom; b = ~a;
    bus_write(4'd1, a);
    address = 4'd1; writedata = b; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    n_cmp++;
    if (readdata !== a) begin
      n_fail++;
      $display("FAIL coll_old: %h, required %h", readdata, a);
    end
    bus_read(4'd1, d);
    n_cmp++;
    if (d !== b) begin
      n_fail++;
      $display("FAIL coll_new: %h, required %h", d, b);
    end
    m_key[1] = b;
    ct0 = model_ct();
    bus_write(4'd8, 32'h1);
    run_op(0, 1'b0, 1'b0, 1'b0);
    cyc = 32'd2;
    bus_write(4'd6, $urandom);
    bus_write(4'd10, $urandom);
    bus_write(4'd13, $urandom);
    bus_read(4'd6, d);
    n_cmp++;
    if (d !== ct0) begin
      n_fail++;
      $display("FAIL ro_ct0: %h, required %h", d, ct0);
    end
    bus_read(4'd10, d);
    n_cmp++;
    if (d !== cyc) begin
      n_fail++;
      $display("FAIL ro_cycles: %0d, required %0d", d, cyc);
    end
    bus_read(4'd13, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL ro_unmapped: %h, required 0", d);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    load_operands(1'b0);
    bus_write(4'd8, 32'h1);
    tick(); tick();
    core_eoc = 1'b1;
    core_ciphertext = {$urandom, $urandom};
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    core_eoc = 1'b0;
    for (int i = 0; i < 4; i++) m_key[i] = '0;
    m_pt[0] = '0; m_pt[1] = '0;
    bus_read(4'd9, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_status: %h, required 0", d);
    end
    bus_read(4'd7, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_ct1: %h, required 0", d);
    end
    bus_read(4'd0, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_key0: %h, required 0", d);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; starts = 0;
    nrst = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    core_eoc = 1'b0; core_ciphertext = '0;
    test_reset();
    test_known_vector();
    test_random_ops();
    test_busy_protect();
    test_stale_eoc();
    test_done_race();
    test_saturate();
    test_irq();
    test_collision_and_ro();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
